// File: rtl/burst_word_decoder_if.sv
// Handshake and word-select bus between a memory controller and burst_word_decoder.
// The controller drives through the master modport; the decoder uses the slave modport.
interface burst_word_decoder_if #(
  parameter int unsigned N             = 16,
  parameter int unsigned NO_ADDR_LINES = 4,
  parameter int unsigned BURST_W       = 4
) ();

  logic                     start;
  logic [NO_ADDR_LINES-1:0] start_addr;
  logic [BURST_W-1:0]       burst_len;
  logic                     wrap_en;
  logic                     stall;
  logic [N-1:0]             word_select_lines;
  logic [NO_ADDR_LINES-1:0] addr_out;
  logic                     busy;
  logic                     done;
  logic                     err;

  modport master (
    output start,
    output start_addr,
    output burst_len,
    output wrap_en,
    output stall,
    input  word_select_lines,
    input  addr_out,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  start,
    input  start_addr,
    input  burst_len,
    input  wrap_en,
    input  stall,
    output word_select_lines,
    output addr_out,
    output busy,
    output done,
    output err
  );

endinterface

// File: rtl/burst_word_decoder.sv
// Registered burst word-select decoder: steps a one-hot select through consecutive words
// from start_addr for burst_len+1 beats, with stall, optional wrap and out-of-range rejection.
module burst_word_decoder #(
  parameter int unsigned N             = 16,
  parameter int unsigned NO_ADDR_LINES = 4,
  parameter int unsigned BURST_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  burst_word_decoder_if.slave bus
);

  localparam logic [NO_ADDR_LINES:0]   NumWords = (NO_ADDR_LINES + 1)'(N);
  localparam logic [NO_ADDR_LINES-1:0] LastAddr = NO_ADDR_LINES'(N - 1);
  localparam logic [N-1:0]             SelZero  = N'(1);
  localparam logic [BURST_W:0]         CntOne   = (BURST_W + 1)'(1);

  typedef enum logic [1:0] {StIdle, StBurst, StDone} state_e;

  state_e                   state_q;
  logic [N-1:0]             sel_q;
  logic [NO_ADDR_LINES-1:0] addr_q;
  logic [BURST_W:0]         remain_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      addr_q   <= '0;
      remain_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // done and err are single-cycle pulses unless re-asserted below
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if ({1'b0, bus.start_addr} < NumWords) begin
              state_q  <= StBurst;
              addr_q   <= bus.start_addr;
              sel_q    <= SelZero << bus.start_addr;
              remain_q <= {1'b0, bus.burst_len} + CntOne;
              busy_q   <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StBurst: begin
          if (!bus.stall) begin
            if (remain_q == CntOne) begin
              state_q  <= StDone;
              sel_q    <= '0;
              remain_q <= '0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end else if (addr_q == LastAddr) begin
              if (bus.wrap_en) begin
                addr_q   <= '0;
                sel_q    <= SelZero;
                remain_q <= remain_q - CntOne;
              end else begin
                // Ran off the top of the array with beats still owed
                state_q  <= StDone;
                sel_q    <= '0;
                remain_q <= '0;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                err_q    <= 1'b1;
              end
            end else begin
              addr_q   <= addr_q + NO_ADDR_LINES'(1);
              sel_q    <= sel_q << 1;
              remain_q <= remain_q - CntOne;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.word_select_lines = sel_q;
  assign bus.addr_out          = addr_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.err               = err_q;

endmodule

// File: tb/tb_burst_word_decoder.sv
// Scoreboard bench for burst_word_decoder: directed bursts on an N=16 and an N=12 instance.
module tb_burst_word_decoder;

  typedef struct packed {
    logic [15:0] sel;
    logic [3:0]  addr;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t q16[$];
  exp_t q12[$];

  always #5 clk = ~clk;

  burst_word_decoder_if #(.N(16), .NO_ADDR_LINES(4), .BURST_W(4)) bus16 ();
  burst_word_decoder_if #(.N(12), .NO_ADDR_LINES(4), .BURST_W(4)) bus12 ();

  burst_word_decoder #(.N(16), .NO_ADDR_LINES(4), .BURST_W(4)) dut16 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus16)
  );

  burst_word_decoder #(.N(12), .NO_ADDR_LINES(4), .BURST_W(4)) dut12 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus12)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic compare_beat(input string tag, input exp_t act, input exp_t req);
    check({tag, "_sel"},  32'(act.sel),  32'(req.sel));
    check({tag, "_addr"}, 32'(act.addr), 32'(req.addr));
    check({tag, "_busy"}, 32'(act.busy), 32'(req.busy));
    check({tag, "_done"}, 32'(act.done), 32'(req.done));
    check({tag, "_err"},  32'(act.err),  32'(req.err));
  endtask

  task automatic push16(input logic [15:0] s, input logic [3:0] a, input logic b,
                        input logic d, input logic e);
    q16.push_back({s, a, b, d, e});
  endtask

  task automatic push12(input logic [15:0] s, input logic [3:0] a, input logic b,
                        input logic d, input logic e);
    q12.push_back({s, a, b, d, e});
  endtask

  // Called at posedge+1; start is sampled on the following posedge.
  task automatic start16(input logic [3:0] a, input logic [3:0] len, input logic wrap);
    bus16.start      = 1'b1;
    bus16.start_addr = a;
    bus16.burst_len  = len;
    bus16.wrap_en    = wrap;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
  endtask

  task automatic start12(input logic [3:0] a, input logic [3:0] len, input logic wrap);
    bus12.start      = 1'b1;
    bus12.start_addr = a;
    bus12.burst_len  = len;
    bus12.wrap_en    = wrap;
    @(posedge clk);
    #1;
    bus12.start = 1'b0;
  endtask

  // Monitors: any presented output must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t act;
    if (rst_n) begin
      act = {bus16.word_select_lines, bus16.addr_out, bus16.busy, bus16.done, bus16.err};
      if (act.busy || act.done || act.err) begin
        if (q16.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL d16_unexpected actual=%0h required=none at %0t", act, $time);
        end else begin
          compare_beat("d16", act, q16.pop_front());
        end
      end else begin
        check("d16_idle_sel", 32'(act.sel), 32'h0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t act;
    if (rst_n) begin
      act = {4'h0, bus12.word_select_lines, bus12.addr_out, bus12.busy, bus12.done, bus12.err};
      if (act.busy || act.done || act.err) begin
        if (q12.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL d12_unexpected actual=%0h required=none at %0t", act, $time);
        end else begin
          compare_beat("d12", act, q12.pop_front());
        end
      end else begin
        check("d12_idle_sel", 32'(act.sel), 32'h0);
      end
    end
  end

  initial begin
    bus16.start = 1'b0; bus16.start_addr = '0; bus16.burst_len = '0;
    bus16.wrap_en = 1'b0; bus16.stall = 1'b0;
    bus12.start = 1'b0; bus12.start_addr = '0; bus12.burst_len = '0;
    bus12.wrap_en = 1'b0; bus12.stall = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_sel16",  32'(bus16.word_select_lines), 32'h0);
    check("rst_addr16", 32'(bus16.addr_out), 32'h0);
    check("rst_busy16", 32'(bus16.busy), 32'h0);
    check("rst_done16", 32'(bus16.done), 32'h0);
    check("rst_err16",  32'(bus16.err), 32'h0);
    check("rst_sel12",  32'(bus12.word_select_lines), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic burst
    push16(16'h0008, 4'd3, 1, 0, 0);
    push16(16'h0010, 4'd4, 1, 0, 0);
    push16(16'h0020, 4'd5, 1, 0, 0);
    push16(16'h0000, 4'd5, 0, 1, 0);
    start16(4'd3, 4'd2, 1'b0);
    repeat (7) @(posedge clk);
    #1;

    // Wrap from 15 to 0
    push16(16'h4000, 4'd14, 1, 0, 0);
    push16(16'h8000, 4'd15, 1, 0, 0);
    push16(16'h0001, 4'd0,  1, 0, 0);
    push16(16'h0002, 4'd1,  1, 0, 0);
    push16(16'h0000, 4'd1,  0, 1, 0);
    start16(4'd14, 4'd3, 1'b1);
    repeat (8) @(posedge clk);
    #1;

    // Early termination at the top word
    push16(16'h4000, 4'd14, 1, 0, 0);
    push16(16'h8000, 4'd15, 1, 0, 0);
    push16(16'h0000, 4'd15, 0, 1, 1);
    start16(4'd14, 4'd3, 1'b0);
    repeat (8) @(posedge clk);
    #1;

    // Stall on the second beat plus a start pulse that must be ignored
    push16(16'h0001, 4'd0, 1, 0, 0);
    push16(16'h0002, 4'd1, 1, 0, 0);
    push16(16'h0002, 4'd1, 1, 0, 0);
    push16(16'h0002, 4'd1, 1, 0, 0);
    push16(16'h0004, 4'd2, 1, 0, 0);
    push16(16'h0008, 4'd3, 1, 0, 0);
    push16(16'h0000, 4'd3, 0, 1, 0);
    start16(4'd0, 4'd3, 1'b0);
    @(posedge clk);
    #1;
    bus16.stall = 1'b1;
    bus16.start = 1'b1;
    bus16.start_addr = 4'd9;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
    @(posedge clk);
    #1;
    bus16.stall = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Maximum length burst covering the whole array
    for (int i = 0; i < 16; i++) push16(16'(1 << i), 4'(i), 1, 0, 0);
    push16(16'h0000, 4'd15, 0, 1, 0);
    start16(4'd0, 4'd15, 1'b0);
    repeat (20) @(posedge clk);
    #1;

    // Non-power-of-two array: rejected addresses and wrap at word 11
    push12(16'h0000, 4'd0, 0, 0, 1);
    start12(4'd13, 4'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    push12(16'h0000, 4'd0, 0, 0, 1);
    start12(4'd12, 4'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    push12(16'h0800, 4'd11, 1, 0, 0);
    push12(16'h0001, 4'd0,  1, 0, 0);
    push12(16'h0000, 4'd0,  0, 1, 0);
    start12(4'd11, 4'd1, 1'b1);
    repeat (6) @(posedge clk);
    #1;

    // Reset asserted on the third beat of an 8-beat burst
    push16(16'h0020, 4'd5, 1, 0, 0);
    push16(16'h0040, 4'd6, 1, 0, 0);
    push16(16'h0080, 4'd7, 1, 0, 0);
    start16(4'd5, 4'd7, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_sel",  32'(bus16.word_select_lines), 32'h0);
    check("midrst_busy", 32'(bus16.busy), 32'h0);
    check("midrst_done", 32'(bus16.done), 32'h0);
    check("midrst_addr", 32'(bus16.addr_out), 32'h0);
    check("midrst_queue", 32'(q16.size()), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push16(16'h0001, 4'd0, 1, 0, 0);
    push16(16'h0002, 4'd1, 1, 0, 0);
    push16(16'h0000, 4'd1, 0, 1, 0);
    start16(4'd0, 4'd1, 1'b0);
    repeat (6) @(posedge clk);
    #1;

    check("q16_drained", 32'(q16.size()), 32'h0);
    check("q12_drained", 32'(q12.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/burst_word_decoder.md
Name: burst_word_decoder

Overview:
- Registered, parametrised successor to the combinational address-to-word-select decoder in the memory array path.
- Accepts a start address and burst length, then steps a one-hot word-select vector through consecutive words, one per cycle.
- Supports stall, wrap-around at the top of the array, out-of-range address detection, and a start/busy/done handshake toward the memory controller.

Parameters:
- N, 16, number of words; any value 2..2^NO_ADDR_LINES, need not be a power of two.
- NO_ADDR_LINES, 4, address width; must satisfy 2^NO_ADDR_LINES >= N.
- BURST_W, 4, width of burst_len; maximum burst is 2^BURST_W beats.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a burst; sampled only in IDLE.
- start_addr  input  NO_ADDR_LINES  first word address.
- burst_len  input  BURST_W  number of beats minus 1.
- wrap_en  input  1  1 = wrap from word N-1 to word 0; 0 = terminate at word N-1.
- stall  input  1  hold the current beat.
- word_select_lines  output  N  one-hot word select, registered.
- addr_out  output  NO_ADDR_LINES  binary address of the active word.
- busy  output  1  high in BURST.
- done  output  1  one-cycle pulse at burst end.
- err  output  1  one-cycle pulse on a rejected start or early termination.

Behaviour:
- Reset (async assert, sync release): state=IDLE; word_select_lines=0; addr_out=0; busy=0; done=0; err=0; internal beat counter=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, BURST, DONE.
- IDLE, start=1 and start_addr<N:
  - Next cycle: state=BURST, addr_out=start_addr, word_select_lines=1<<start_addr, busy=1.
  - Beats remaining = burst_len+1 (counter width BURST_W+1, so no overflow at burst_len = all ones).
  - Latency from start to first select is 1 cycle.
- IDLE, start=1 and start_addr>=N: err=1 for one cycle, state stays IDLE, word_select_lines stays 0.
- IDLE, start=0: outputs hold their idle values.
- BURST, stall=1: word_select_lines, addr_out and the counter hold; a stall holds indefinitely.
- BURST, stall=0, last beat (remaining==1): next cycle state=DONE, word_select_lines=0, busy=0, done=1.
- BURST, stall=0, not last beat:
  - Address advances by 1.
  - At addr_out==N-1 with wrap_en=1: next address is 0.
  - At addr_out==N-1 with wrap_en=0: early termination; next cycle state=DONE with done=1 and err=1 together, word_select_lines=0.
- wrap_en is sampled every beat, not latched at start.
- DONE: lasts exactly one cycle, then IDLE. done and err deassert in that transition.
- start is ignored in BURST and DONE; the earliest new start is sampled in the first IDLE cycle after DONE.
- stall has no effect outside BURST.
- Invariant: word_select_lines is exactly one-hot in BURST and all-zero in every other state. addr_out holds its last value outside BURST.
- Reset asserted mid-burst: all outputs clear immediately, no done pulse; after release the block is in IDLE.

Test Plan:
- Reset mid-burst: start_addr=5, burst_len=7, assert rst_n=0 on beat 3 -> select 0 in the same cycle, no done; after release a start_addr=0 burst runs normally.
- Basic burst: N=16, start_addr=3, burst_len=2 -> selects 0x0008, 0x0010, 0x0020 on cycles 1-3; done=1 on cycle 4; busy high cycles 1-3.
- Wrap: start_addr=14, burst_len=3, wrap_en=1 -> addr_out 14, 15, 0, 1; then done=1, err=0.
- Early termination: start_addr=14, burst_len=3, wrap_en=0 -> addr_out 14, 15; then done=1 and err=1 in the same cycle.
- Stall and ignored start: start_addr=0, burst_len=3, stall high for 2 cycles on beat 1 -> 0x0002 held 3 cycles total; start pulsed during BURST ignored; burst ends with done on cycle 7.
- Out of range and max length: N=12, start_addr=13 -> err pulse, select stays 0. N=16, start_addr=0, burst_len=15 -> 16 beats 0x0001..0x8000, then done.
